clk_div_gen: RTL and testbench

CLK_DIV_GEN -- requirements
Module: clk_div_gen

---
 rtl/clk_div_gen.sv | 247 ++++++++++++++++++++++++
 tb/tb_clk_div_gen.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/clk_div_gen.sv
// ---------------------------------------------------------------------------
// clk_div_gen
//
// Multi-channel programmable clock divider. It runs on a single reference
// clock and waits for a stable PLL lock before it starts. Every channel
// derives a square wave and a one-cycle clock-enable from one shared time
// base, so channels programmed alike stay cycle-aligned.
//
// Ports
//   ref_CLK    in   1            sole clock, rising edge
//   RST        in   1            synchronous active-high reset
//   lock       in   1            PLL lock status, synchronous to ref_CLK
//   ch_en      in   N_CH         per-channel enable
//   div        in   N_CH*DIV_W   per-channel period, channel i at [i*DIV_W +: DIV_W]
//   phase      in   N_CH*DIV_W   per-channel start offset, same packing
//   load       in   1            strobe: capture div/phase into the shadow registers
//   ready      out  1            high while running
//   div_clk    out  N_CH         divided square waves (registered)
//   ce         out  N_CH         one pulse per channel period (registered)
//   lock_lost  out  1            sticky flag, set on lock loss while running
// ---------------------------------------------------------------------------
module clk_div_gen #(
    parameter int N_CH      = 4,
    parameter int DIV_W     = 8,
    parameter int LOCK_WAIT = 16
) (
    input  logic                    ref_CLK,
    input  logic                    RST,
    input  logic                    lock,
    input  logic [N_CH-1:0]         ch_en,
    input  logic [N_CH*DIV_W-1:0]   div,
    input  logic [N_CH*DIV_W-1:0]   phase,
    input  logic                    load,
    output logic                    ready,
    output logic [N_CH-1:0]         div_clk,
    output logic [N_CH-1:0]         ce,
    output logic                    lock_lost
);

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        ALIGN     = 2'd1,
        RUN       = 2'd2
    } state_t;

    localparam logic [7:0] LOCK_WAIT_C = 8'(LOCK_WAIT);

    // Divisors 0 and 1 cannot make a square wave; they behave as 2.
    function automatic logic [DIV_W-1:0] eff_div(input logic [DIV_W-1:0] d);
        if (d < DIV_W'(2)) begin
            return DIV_W'(2);
        end else begin
            return d;
        end
    endfunction

    // An out-of-range phase would start the counter past its wrap point.
    function automatic logic [DIV_W-1:0] eff_phase(input logic [DIV_W-1:0] ph,
                                                   input logic [DIV_W-1:0] d_eff);
        if (ph < d_eff) begin
            return ph;
        end else begin
            return '0;
        end
    endfunction

    state_t             state_r;
    logic [7:0]         lock_cnt_r;
    logic               ready_r;
    logic               lock_lost_r;

    // Per-channel state
    logic [DIV_W-1:0]   sh_div_r  [N_CH];
    logic [DIV_W-1:0]   sh_ph_r   [N_CH];
    logic [DIV_W-1:0]   act_div_r [N_CH];
    logic [DIV_W-1:0]   act_ph_r  [N_CH];
    logic [DIV_W-1:0]   cnt_r     [N_CH];
    logic [N_CH-1:0]    pend_r;
    logic [N_CH-1:0]    live_r;      // cnt_r holds a valid running count
    logic [N_CH-1:0]    div_clk_r;
    logic [N_CH-1:0]    ce_r;

    // Next-state values
    logic [DIV_W-1:0]   sh_div_s  [N_CH];
    logic [DIV_W-1:0]   sh_ph_s   [N_CH];
    logic [DIV_W-1:0]   act_div_s [N_CH];
    logic [DIV_W-1:0]   act_ph_s  [N_CH];
    logic [DIV_W-1:0]   cnt_s     [N_CH];
    logic [DIV_W-1:0]   d_cur_s   [N_CH];
    logic [DIV_W-1:0]   d_nxt_s   [N_CH];
    logic [N_CH-1:0]    pend_s;
    logic [N_CH-1:0]    live_s;
    logic [N_CH-1:0]    div_clk_s;
    logic [N_CH-1:0]    ce_s;

    logic               in_align_s;
    logic               run_stay_s;

    assign in_align_s = (state_r == ALIGN);
    // Staying in RUN needs lock this cycle; a single low cycle drops out.
    assign run_stay_s = (state_r == RUN) && lock;

    assign ready     = ready_r;
    assign lock_lost = lock_lost_r;
    assign div_clk   = div_clk_r;
    assign ce        = ce_r;

    // Lock-qualification FSM with its registered status outputs.
    always_ff @(posedge ref_CLK) begin
        if (RST) begin
            state_r     <= WAIT_LOCK;
            lock_cnt_r  <= 8'd0;
            ready_r     <= 1'b0;
            lock_lost_r <= 1'b0;
        end else begin
            case (state_r)
                WAIT_LOCK: begin
                    ready_r <= 1'b0;
                    if (lock_cnt_r == LOCK_WAIT_C) begin
                        state_r    <= ALIGN;
                        lock_cnt_r <= 8'd0;
                    end else if (lock) begin
                        lock_cnt_r <= lock_cnt_r + 8'd1;
                    end else begin
                        lock_cnt_r <= 8'd0;
                    end
                end
                ALIGN: begin
                    state_r    <= RUN;
                    ready_r    <= 1'b1;
                    lock_cnt_r <= 8'd0;
                end
                RUN: begin
                    lock_cnt_r <= 8'd0;
                    if (!lock) begin
                        state_r     <= WAIT_LOCK;
                        ready_r     <= 1'b0;
                        lock_lost_r <= 1'b1;
                    end else begin
                        ready_r <= 1'b1;
                    end
                end
                default: begin
                    state_r    <= WAIT_LOCK;
                    ready_r    <= 1'b0;
                    lock_cnt_r <= 8'd0;
                end
            endcase
        end
    end

    // Per-channel next state. Outputs are computed from the next count so
    // the registered div_clk/ce line up with the count they describe.
    always_comb begin
        for (int i = 0; i < N_CH; i++) begin
            act_div_s[i] = act_div_r[i];
            act_ph_s[i]  = act_ph_r[i];
            cnt_s[i]     = '0;
            live_s[i]    = 1'b0;
            d_cur_s[i]   = eff_div(act_div_r[i]);

            if (load) begin
                sh_div_s[i] = div[i*DIV_W +: DIV_W];
                sh_ph_s[i]  = phase[i*DIV_W +: DIV_W];
                pend_s[i]   = 1'b1;
            end else begin
                sh_div_s[i] = sh_div_r[i];
                sh_ph_s[i]  = sh_ph_r[i];
                pend_s[i]   = pend_r[i];
            end

            if (in_align_s) begin
                // Startup: take whatever is in the shadow and honour phase.
                act_div_s[i] = sh_div_r[i];
                act_ph_s[i]  = sh_ph_r[i];
                pend_s[i]    = load;
                live_s[i]    = ch_en[i];
                if (ch_en[i]) begin
                    cnt_s[i] = eff_phase(sh_ph_r[i], eff_div(sh_div_r[i]));
                end else begin
                    cnt_s[i] = '0;
                end
            end else if (run_stay_s) begin
                if (!ch_en[i]) begin
                    cnt_s[i]  = '0;
                    live_s[i] = 1'b0;
                end else if (!live_r[i]) begin
                    // Freshly enabled: count from zero, no phase.
                    cnt_s[i]  = '0;
                    live_s[i] = 1'b1;
                end else if (cnt_r[i] >= d_cur_s[i] - DIV_W'(1)) begin
                    cnt_s[i]  = '0;
                    live_s[i] = 1'b1;
                    // A load in this very cycle defers the swap by one period.
                    if (pend_r[i] && !load) begin
                        act_div_s[i] = sh_div_r[i];
                        act_ph_s[i]  = sh_ph_r[i];
                        pend_s[i]    = 1'b0;
                    end else begin
                        act_div_s[i] = act_div_r[i];
                        act_ph_s[i]  = act_ph_r[i];
                    end
                end else begin
                    cnt_s[i]  = cnt_r[i] + DIV_W'(1);
                    live_s[i] = 1'b1;
                end
            end else begin
                cnt_s[i]  = '0;
                live_s[i] = 1'b0;
            end

            d_nxt_s[i]   = eff_div(act_div_s[i]);
            div_clk_s[i] = live_s[i] && (cnt_s[i] < (d_nxt_s[i] >> 1));
            ce_s[i]      = live_s[i] && (cnt_s[i] == d_nxt_s[i] - DIV_W'(1));
        end
    end

    // Per-channel registers and registered outputs.
    always_ff @(posedge ref_CLK) begin
        if (RST) begin
            for (int i = 0; i < N_CH; i++) begin
                sh_div_r[i]  <= DIV_W'(2);
                sh_ph_r[i]   <= '0;
                act_div_r[i] <= DIV_W'(2);
                act_ph_r[i]  <= '0;
                cnt_r[i]     <= '0;
            end
            pend_r    <= '0;
            live_r    <= '0;
            div_clk_r <= '0;
            ce_r      <= '0;
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                sh_div_r[i]  <= sh_div_s[i];
                sh_ph_r[i]   <= sh_ph_s[i];
                act_div_r[i] <= act_div_s[i];
                act_ph_r[i]  <= act_ph_s[i];
                cnt_r[i]     <= cnt_s[i];
            end
            pend_r    <= pend_s;
            live_r    <= live_s;
            div_clk_r <= div_clk_s;
            ce_r      <= ce_s;
        end
    end

endmodule

// File: tb/tb_clk_div_gen.sv
module tb_clk_div_gen;

    logic        ref_CLK = 1'b0;
    logic        RST;
    logic        lock;
    logic [3:0]  ch_en;
    logic [31:0] div;
    logic [31:0] phase;
    logic        load;
    logic        ready;
    logic [3:0]  div_clk;
    logic [3:0]  ce;
    logic        lock_lost;

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        logic [3:0] en;
        logic [3:0] clk;
        logic [3:0] ce;
    } vec_t;

    vec_t tbl [16];
    logic clk0_hist [600];

    // Load mid-period (4 -> 8 -> 6, second load wins)
    bit mp_clk [14] = '{1'b0,1'b0,1'b1,1'b1,1'b1,1'b0,1'b0,1'b0,1'b1,1'b1,1'b1,1'b0,1'b0,1'b0};
    bit mp_ce  [14] = '{1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1};
    // Load on a terminal count (4 -> 6): one extra 4-cycle period first
    bit lt_clk [10] = '{1'b1,1'b1,1'b0,1'b0,1'b1,1'b1,1'b1,1'b0,1'b0,1'b0};
    bit lt_ce  [10] = '{1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1};

    clk_div_gen #(.N_CH(4), .DIV_W(8), .LOCK_WAIT(16)) dut (
        .ref_CLK   (ref_CLK),
        .RST       (RST),
        .lock      (lock),
        .ch_en     (ch_en),
        .div       (div),
        .phase     (phase),
        .load      (load),
        .ready     (ready),
        .div_clk   (div_clk),
        .ce        (ce),
        .lock_lost (lock_lost)
    );

    always #5 ref_CLK = ~ref_CLK;

    task automatic step();
        @(posedge ref_CLK);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_ready"}, 32'(ready), 32'd0);
        chk({tag, "_div_clk"}, 32'(div_clk), 32'd0);
        chk({tag, "_ce"}, 32'(ce), 32'd0);
    endtask

    // 17 lock-high samples during which ready must stay low.
    task automatic wait_ready17(input string tag);
        for (int k = 1; k <= 17; k++) begin
            step();
            chk({tag, "_ready_low"}, 32'(ready), 32'd0);
        end
    endtask

    // Step until ce[0] is seen, bounded.
    task automatic wait_ce0();
        int n;
        n = 0;
        step();
        while (ce[0] !== 1'b1 && n < 64) begin
            step();
            n++;
        end
        chk("wait_ce0", 32'(ce[0]), 32'd1);
    endtask

    initial begin
        tbl[0]  = '{4'hF, 4'b1111, 4'b0000};
        tbl[1]  = '{4'hF, 4'b1011, 4'b0100};
        tbl[2]  = '{4'hF, 4'b0100, 4'b0000};
        tbl[3]  = '{4'hF, 4'b0000, 4'b1101};
        tbl[4]  = '{4'hF, 4'b1101, 4'b0010};
        tbl[5]  = '{4'hF, 4'b1011, 4'b0100};
        tbl[6]  = '{4'hF, 4'b0110, 4'b0000};
        tbl[7]  = '{4'hF, 4'b0000, 4'b1101};
        tbl[8]  = '{4'hF, 4'b1101, 4'b0000};
        tbl[9]  = '{4'hF, 4'b1001, 4'b0110};
        tbl[10] = '{4'hF, 4'b0110, 4'b0000};
        tbl[11] = '{4'hF, 4'b0010, 4'b1101};
        tbl[12] = '{4'hE, 4'b1100, 4'b0000};
        tbl[13] = '{4'hF, 4'b1001, 4'b0100};
        tbl[14] = '{4'hF, 4'b0101, 4'b0010};
        tbl[15] = '{4'hF, 4'b0010, 4'b1100};

        RST   = 1'b1;
        lock  = 1'b0;
        load  = 1'b0;
        ch_en = 4'hF;
        // ch3: div 4 phase 7, ch2: div 0, ch1: div 5, ch0: div 4
        div   = {8'd4, 8'd0, 8'd5, 8'd4};
        phase = {8'd7, 8'd0, 8'd0, 8'd0};
        step();
        step();
        check_idle("reset");
        chk("reset_lock_lost", 32'(lock_lost), 32'd0);

        // Load before lock
        RST  = 1'b0;
        load = 1'b1;
        step();
        load = 1'b0;
        step();
        check_idle("wait_lock");

        // Lock high for 10, low for 1, then restart the count
        lock = 1'b1;
        for (int k = 0; k < 10; k++) begin
            step();
            chk("pre_drop_ready", 32'(ready), 32'd0);
        end
        lock = 1'b0;
        step();
        chk("drop10_ready", 32'(ready), 32'd0);
        lock = 1'b1;
        wait_ready17("lock1");

        // Table: first RUN cycles, including a channel-0 enable drop
        for (int t = 0; t < 16; t++) begin
            ch_en = tbl[t].en;
            step();
            chk("tbl_ready", 32'(ready), 32'd1);
            chk($sformatf("tbl%0d_div_clk", t), 32'(div_clk), 32'(tbl[t].clk));
            chk($sformatf("tbl%0d_ce", t), 32'(ce), 32'(tbl[t].ce));
        end
        ch_en = 4'hF;

        // Lock loss, then resync with phases (ch0 6/0, ch1 6/3)
        div   = {8'd4, 8'd0, 8'd6, 8'd6};
        phase = {8'd7, 8'd0, 8'd3, 8'd0};
        load  = 1'b1;
        step();
        load  = 1'b0;
        lock  = 1'b0;
        step();
        check_idle("lost");
        chk("lost_flag", 32'(lock_lost), 32'd1);
        lock = 1'b1;
        wait_ready17("lock2");
        for (int t = 0; t < 600; t++) begin
            step();
            if (t == 0) begin
                chk("resync_ready", 32'(ready), 32'd1);
                chk("resync_lock_lost", 32'(lock_lost), 32'd1);
            end
            chk("ph_clk0", 32'(div_clk[0]), 32'((t % 6) < 3));
            chk("ph_clk1", 32'(div_clk[1]), 32'(((t + 3) % 6) < 3));
            chk("ph_ce0", 32'(ce[0]), 32'((t % 6) == 5));
            chk("ph_ce1", 32'(ce[1]), 32'(((t + 3) % 6) == 5));
            clk0_hist[t] = div_clk[0];
            if (t >= 3) begin
                chk("ph_lag3", 32'(div_clk[1]), 32'(clk0_hist[t-3]));
            end
        end

        // Back to period 4 on channel 0
        step();
        div[7:0] = 8'd4;
        load = 1'b1;
        step();
        load = 1'b0;
        wait_ce0();
        wait_ce0();
        step();
        step();
        chk("mid_pre_clk0", 32'(div_clk[0]), 32'd1);
        // Two loads mid-period; 6 wins, applied after the current period
        for (int i = 0; i < 14; i++) begin
            if (i == 0) begin
                div[7:0] = 8'd8;
                load = 1'b1;
            end else if (i == 1) begin
                div[7:0] = 8'd6;
                load = 1'b1;
            end else begin
                load = 1'b0;
            end
            step();
            chk($sformatf("mid%0d_clk0", i), 32'(div_clk[0]), 32'(mp_clk[i]));
            chk($sformatf("mid%0d_ce0", i), 32'(ce[0]), 32'(mp_ce[i]));
        end
        load = 1'b0;

        // Load exactly on a terminal count
        step();
        div[7:0] = 8'd4;
        load = 1'b1;
        step();
        load = 1'b0;
        wait_ce0();
        wait_ce0();
        for (int i = 0; i < 10; i++) begin
            if (i == 0) begin
                div[7:0] = 8'd6;
                load = 1'b1;
            end else begin
                load = 1'b0;
            end
            step();
            chk($sformatf("term%0d_clk0", i), 32'(div_clk[0]), 32'(lt_clk[i]));
            chk($sformatf("term%0d_ce0", i), 32'(ce[0]), 32'(lt_ce[i]));
        end
        load = 1'b0;

        // div = 1 behaves as 2
        step();
        div[7:0] = 8'd1;
        load = 1'b1;
        step();
        load = 1'b0;
        wait_ce0();
        for (int i = 0; i < 6; i++) begin
            step();
            chk("div1_clk0", 32'(div_clk[0]), 32'((i % 2) == 0));
            chk("div1_ce0", 32'(ce[0]), 32'((i % 2) == 1));
        end

        // Reset beats a simultaneous load
        div   = 32'h04040404;
        phase = 32'h0;
        load  = 1'b1;
        RST   = 1'b1;
        step();
        RST   = 1'b0;
        load  = 1'b0;
        check_idle("rst_run");
        chk("rst_run_lock_lost", 32'(lock_lost), 32'd0);
        wait_ready17("lock3");
        for (int i = 0; i < 4; i++) begin
            step();
            chk("post_rst_ready", 32'(ready), 32'd1);
            chk("post_rst_clk0", 32'(div_clk[0]), 32'((i % 2) == 0));
            chk("post_rst_ce0", 32'(ce[0]), 32'((i % 2) == 1));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
